// File: rtl/pfd_cal_sequencer.sv
// pfd_cal_sequencer: walks every time-interleaved ADC channel, waits for the
// averager result and accumulates a saturated per-channel PFD offset.
// Optional macro PFD_CAL_TIMEOUT_EN adds a MEASURE timeout with a sticky err flag.
module pfd_cal_sequencer #(
  parameter int unsigned Nti     = 16,
  parameter int unsigned Nadc    = 8,
  parameter int unsigned Nsettle = 8
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_start,
  input  logic                                    i_abort,
  input  logic [3:0]                              i_n_iter,
  input  logic [Nsettle-1:0]                      i_settle_cycles,
  input  logic [Nadc-1:0]                         i_avg_in,
  input  logic                                    i_avg_valid,
  input  logic [15:0]                             i_timeout_lim,
  output logic [((Nti > 1) ? $clog2(Nti) : 1)-1:0] o_chan_sel,
  output logic                                    o_meas_en,
  output logic [Nti*Nadc-1:0]                     o_pfd_offset_out,
  output logic                                    o_busy,
  output logic                                    o_done,
  output logic                                    o_err
);

  localparam int unsigned CW = (Nti > 1) ? $clog2(Nti) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_MEASURE, S_UPDATE, S_DONE
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_chan;
  logic [3:0]         r_iter;
  logic [3:0]         r_niter;
  logic [Nsettle-1:0] r_settle_lim;
  logic [Nsettle-1:0] r_settle_cnt;
  logic [Nadc-1:0]    r_avg;
  logic               r_skip;
  logic               r_meas_en;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [Nadc-1:0]    r_off [Nti];

  logic [Nadc-1:0]    w_cur;
  logic [Nadc:0]      w_sum;
  logic [Nadc-1:0]    w_sat;
  logic               w_last_chan;
  logic               w_last_iter;
  logic               w_timeout;

`ifdef PFD_CAL_TIMEOUT_EN
  logic [15:0]        r_to_lim;
  logic [15:0]        r_to_cnt;

  // Timeout fires on the MEASURE cycle that completes timeout_lim cycles
  assign w_timeout = ({1'b0, r_to_cnt} + 17'd1) >= {1'b0, r_to_lim};
`else
  logic               w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^i_timeout_lim;
`endif

  // Saturating accumulate of the captured average into the selected offset
  assign w_cur = r_off[r_chan];
  assign w_sum = {w_cur[Nadc-1], w_cur} + {r_avg[Nadc-1], r_avg};
  always_comb begin
    w_sat = w_sum[Nadc-1:0];
    if (w_sum[Nadc] != w_sum[Nadc-1]) begin
      w_sat = w_sum[Nadc] ? {1'b1, {(Nadc-1){1'b0}}} : {1'b0, {(Nadc-1){1'b1}}};
    end
  end

  assign w_last_chan = (r_chan == CW'(Nti - 1));
  assign w_last_iter = ({1'b0, r_iter} + 5'd1) >= {1'b0, r_niter};

  // Flatten the offset array onto the output bus, channel i at bits [i*Nadc +: Nadc]
  for (genvar g = 0; g < Nti; g++) begin : g_off
    assign o_pfd_offset_out[g*Nadc +: Nadc] = r_off[g];
  end

  // Calibration FSM with registered outputs; rst beats abort beats everything else
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_chan       <= '0;
      r_iter       <= '0;
      r_niter      <= '0;
      r_settle_lim <= '0;
      r_settle_cnt <= '0;
      r_avg        <= '0;
      r_skip       <= 1'b0;
      r_meas_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      for (int i = 0; i < Nti; i++) r_off[i] <= '0;
`ifdef PFD_CAL_TIMEOUT_EN
      r_to_lim     <= '0;
      r_to_cnt     <= '0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_meas_en <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state      <= S_SELECT;
              r_busy       <= 1'b1;
              r_chan       <= '0;
              r_iter       <= '0;
              r_err        <= 1'b0;
              r_niter      <= (i_n_iter == 4'd0) ? 4'd1 : i_n_iter;
              r_settle_lim <= i_settle_cycles;
`ifdef PFD_CAL_TIMEOUT_EN
              r_to_lim     <= i_timeout_lim;
`endif
            end
          end
          S_SELECT: begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= r_settle_lim;
          end
          S_SETTLE: begin
            if (r_settle_cnt == '0) begin
              r_state   <= S_MEASURE;
              r_meas_en <= 1'b1;
`ifdef PFD_CAL_TIMEOUT_EN
              r_to_cnt  <= '0;
`endif
            end else begin
              r_settle_cnt <= r_settle_cnt - 1'b1;
            end
          end
          S_MEASURE: begin
            if (i_avg_valid) begin
              r_state <= S_UPDATE;
              r_avg   <= i_avg_in;
              r_skip  <= 1'b0;
            end else if (w_timeout) begin
              r_state <= S_UPDATE;
              r_skip  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_meas_en <= 1'b1;
`ifdef PFD_CAL_TIMEOUT_EN
              r_to_cnt  <= r_to_cnt + 16'd1;
`endif
            end
          end
          S_UPDATE: begin
            if (!r_skip) r_off[r_chan] <= w_sat;
            if (!w_last_chan) begin
              r_chan  <= r_chan + 1'b1;
              r_state <= S_SELECT;
            end else begin
              r_chan <= '0;
              r_iter <= r_iter + 4'd1;
              if (w_last_iter) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_SELECT;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_chan_sel = r_chan;
  assign o_meas_en  = r_meas_en;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
`ifdef PFD_CAL_TIMEOUT_EN
  assign o_err      = r_err;
`else
  assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_pfd_cal_sequencer.sv
// Directed self-checking bench for pfd_cal_sequencer (Nti=4, Nadc=8).
module tb_pfd_cal_sequencer;

  localparam int unsigned NTI  = 4;
  localparam int unsigned NADC = 8;
  localparam int unsigned NSET = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [3:0]          n_iter = 4'd1;
  logic [NSET-1:0]     settle_cycles = '0;
  logic [NADC-1:0]     avg_in = '0;
  logic                avg_valid = 1'b0;
  logic [15:0]         timeout_lim = 16'd10;
  logic [1:0]          chan_sel;
  logic                meas_en;
  logic [NTI*NADC-1:0] offs;
  logic                busy;
  logic                done;
  logic                err;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  pfd_cal_sequencer #(.Nti(NTI), .Nadc(NADC), .Nsettle(NSET)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_n_iter(n_iter), .i_settle_cycles(settle_cycles), .i_avg_in(avg_in),
    .i_avg_valid(avg_valid), .i_timeout_lim(timeout_lim),
    .o_chan_sel(chan_sel), .o_meas_en(meas_en), .o_pfd_offset_out(offs),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic signed [7:0] off(input int ch);
    return offs[ch*8 +: 8];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_run(input logic [3:0] n, input logic [7:0] s);
    n_iter = n; settle_cycles = s; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Bounded wait for meas_en; lat counts negedges waited
  task automatic wait_meas(output int lat);
    lat = 0;
    while (meas_en !== 1'b1 && lat < 200) begin tick(1); lat++; end
    vectors++;
    if (lat >= 200) begin
      miscompares++;
      $display("FAIL meas_wait: meas_en never rose within %0d cycles (required within 200)", lat);
    end
  endtask

  task automatic serve(input logic [7:0] v, input logic [1:0] ch);
    int lat;
    wait_meas(lat);
    vectors++;
    if (chan_sel !== ch) begin
      miscompares++;
      $display("FAIL chan_sel: got %0d required %0d", chan_sel, ch);
    end
    avg_in = v; avg_valid = 1'b1;
    tick(1);
    avg_valid = 1'b0; avg_in = '0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy === 1'b1 && k < 200) begin tick(1); k++; end
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(2);
    vectors++;
    if ({busy, done, meas_en, err, chan_sel} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b required 000000", {busy, done, meas_en, err, chan_sel});
    end
    vectors++;
    if (offs !== '0) begin
      miscompares++;
      $display("FAIL reset_offs: got %h required 0", offs);
    end
    rst = 1'b0; tick(1);
  endtask

  task automatic test_basic();
    logic signed [7:0] exp [4] = '{8'sd3, -8'sd5, 8'sd0, 8'sd7};
    int lat, d0;
    d0 = done_cnt;
    start_run(4'd1, 8'd2);
    wait_meas(lat);
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL settle_lat2: got %0d required 4", lat);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_run: got %b required 1", busy);
    end
    for (int i = 0; i < 4; i++) serve(exp[i], 2'(i));
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (off(i) !== exp[i]) begin
        miscompares++;
        $display("FAIL basic_off%0d: got %0d required %0d", i, off(i), exp[i]);
      end
    end
    vectors++;
    if (done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL basic_done: got %0d pulses required 1", done_cnt - d0);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_saturation();
    logic signed [7:0] v1 [4] = '{8'sd117, -8'sd115, 8'sd0, 8'sd0};
    logic signed [7:0] v2 [4] = '{8'sd20, -8'sd20, 8'sd0, -8'sd7};
    logic signed [7:0] e1 [4] = '{8'sd120, -8'sd120, 8'sd0, 8'sd7};
    logic signed [7:0] e2 [4] = '{8'sd127, -8'sd128, 8'sd0, 8'sd0};
    start_run(4'd1, 8'd0);
    for (int i = 0; i < 4; i++) serve(v1[i], 2'(i));
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (off(i) !== e1[i]) begin
        miscompares++;
        $display("FAIL pre_sat_off%0d: got %0d required %0d", i, off(i), e1[i]);
      end
    end
    start_run(4'd1, 8'd0);
    for (int i = 0; i < 4; i++) serve(v2[i], 2'(i));
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (off(i) !== e2[i]) begin
        miscompares++;
        $display("FAIL sat_off%0d: got %0d required %0d", i, off(i), e2[i]);
      end
    end
  endtask

  task automatic test_n_iter();
    int d0;
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    d0 = done_cnt;
    start_run(4'd2, 8'd1);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) serve(8'sd1, 2'(i));
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (off(i) !== 8'sd2) begin
        miscompares++;
        $display("FAIL iter2_off%0d: got %0d required 2", i, off(i));
      end
    end
    vectors++;
    if (done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL iter2_done: got %0d pulses required 1", done_cnt - d0);
    end
  endtask

  // n_iter=0 acts as one pass; inputs changed after start must not matter
  task automatic test_n_iter_zero_sampling();
    int lat, d0;
    d0 = done_cnt;
    start_run(4'd0, 8'd0);
    n_iter = 4'd5; settle_cycles = 8'd50;
    wait_meas(lat);
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("FAIL settle_lat0: got %0d required 2", lat);
    end
    for (int i = 0; i < 4; i++) serve(8'sd1, 2'(i));
    wait_idle();
    vectors++;
    if (done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL iter0_done: got %0d pulses required 1", done_cnt - d0);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (off(i) !== 8'sd3) begin
        miscompares++;
        $display("FAIL iter0_off%0d: got %0d required 3", i, off(i));
      end
    end
  endtask

  task automatic test_abort();
    logic signed [7:0] exp [4] = '{8'sd4, 8'sd4, 8'sd3, 8'sd3};
    int lat, d0;
    d0 = done_cnt;
    start_run(4'd1, 8'd1);
    avg_in = 8'sd99; avg_valid = 1'b1;
    tick(1);
    avg_valid = 1'b0; avg_in = '0;
    serve(8'sd1, 2'd0);
    serve(8'sd1, 2'd1);
    wait_meas(lat);
    vectors++;
    if (chan_sel !== 2'd2) begin
      miscompares++;
      $display("FAIL abort_chan: got %0d required 2", chan_sel);
    end
    avg_in = 8'sd50; avg_valid = 1'b1; abort = 1'b1;
    tick(1);
    avg_valid = 1'b0; abort = 1'b0; avg_in = '0;
    vectors++;
    if ({busy, meas_en} !== 2'b00) begin
      miscompares++;
      $display("FAIL abort_idle: got busy,meas_en=%b required 00", {busy, meas_en});
    end
    tick(3);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (off(i) !== exp[i]) begin
        miscompares++;
        $display("FAIL abort_off%0d: got %0d required %0d", i, off(i), exp[i]);
      end
    end
    vectors++;
    if (done_cnt - d0 !== 0) begin
      miscompares++;
      $display("FAIL abort_done: got %0d pulses required 0", done_cnt - d0);
    end
  endtask

`ifdef PFD_CAL_TIMEOUT_EN
  task automatic test_timeout();
    logic signed [7:0] exp [4] = '{8'sd5, 8'sd4, 8'sd4, 8'sd4};
    int lat, n, d0;
    d0 = done_cnt;
    timeout_lim = 16'd10;
    start_run(4'd1, 8'd0);
    timeout_lim = 16'd3;
    serve(8'sd1, 2'd0);
    wait_meas(lat);
    n = 0;
    while (meas_en === 1'b1 && n < 50) begin tick(1); n++; end
    vectors++;
    if (n !== 10) begin
      miscompares++;
      $display("FAIL to_cycles: got %0d required 10", n);
    end
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL to_err: got %b required 1", err);
    end
    serve(8'sd1, 2'd2);
    serve(8'sd1, 2'd3);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (off(i) !== exp[i]) begin
        miscompares++;
        $display("FAIL to_off%0d: got %0d required %0d", i, off(i), exp[i]);
      end
    end
    vectors++;
    if ({done_cnt - d0, err} !== {32'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL to_done_err: got done=%0d err=%b required done=1 err=1", done_cnt - d0, err);
    end
    start_run(4'd1, 8'd0);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL to_err_clear: got %b required 0", err);
    end
    abort = 1'b1; tick(1); abort = 1'b0; tick(1);
  endtask
`else
  task automatic test_no_timeout();
    int lat, d0;
    d0 = done_cnt;
    timeout_lim = 16'd2;
    start_run(4'd1, 8'd0);
    serve(8'sd1, 2'd0);
    wait_meas(lat);
    tick(30);
    vectors++;
    if ({meas_en, err, chan_sel} !== 4'b1001) begin
      miscompares++;
      $display("FAIL hold_meas: got meas_en,err,chan=%b required 1001", {meas_en, err, chan_sel});
    end
    serve(8'sd1, 2'd1);
    serve(8'sd1, 2'd2);
    serve(8'sd1, 2'd3);
    wait_idle();
    vectors++;
    if ({done_cnt - d0, off(1)} !== {32'd1, 8'sd5}) begin
      miscompares++;
      $display("FAIL hold_done: got done=%0d off1=%0d required done=1 off1=5", done_cnt - d0, off(1));
    end
  endtask
`endif

  task automatic test_busy_start_and_reset();
    int lat;
    start_run(4'd1, 8'd4);
    serve(8'sd1, 2'd0);
    wait_meas(lat);
    start = 1'b1; tick(1); start = 1'b0;
    vectors++;
    if ({busy, meas_en, chan_sel} !== 4'b1101) begin
      miscompares++;
      $display("FAIL start_busy: got busy,meas_en,chan=%b required 1101", {busy, meas_en, chan_sel});
    end
    serve(8'sd1, 2'd1);
    tick(2);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    tick(1);
    vectors++;
    if ({busy, meas_en, done, err, chan_sel} !== 6'b0) begin
      miscompares++;
      $display("FAIL rst_mid_ctl: got %b required 000000", {busy, meas_en, done, err, chan_sel});
    end
    vectors++;
    if (offs !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_offs: got %h required 0", offs);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    tick(2);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_no_start: got busy=%b required 0", busy);
    end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_basic();
    test_saturation();
    test_n_iter();
    test_n_iter_zero_sampling();
    test_abort();
`ifdef PFD_CAL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_busy_start_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pfd_cal_sequencer.md
PFD_CAL_SEQUENCER -- requirements
Module: pfd_cal_sequencer

Interface
REQ-001 Parameter Nti, default 16: number of time-interleaved ADC channels to calibrate.
REQ-002 Parameter Nadc, default 8: ADC/offset word width, signed two's complement.
REQ-003 Parameter Nsettle, default 8: counter width for the settle interval.
REQ-004 Ports, one per line:
clk  input  1  the block's single clock; every register updates on its rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse that begins a calibration run; honoured only in IDLE.
abort  input  1  level; returns the FSM to IDLE on the next edge.
n_iter  input  4  number of full passes over all channels; 0 is treated as 1.
settle_cycles  input  Nsettle  wait after a channel select, before measurement starts.
avg_in  input  Nadc  signed average from the averager for the selected channel.
avg_valid  input  1  one-cycle pulse: avg_in is valid.
timeout_lim  input  16  maximum cycles to wait for avg_valid.
chan_sel  output  $clog2(Nti)  channel currently being measured.
meas_en  output  1  enables the averager (maps to en_pfd_cal).
pfd_offset_out  output  Nadc x Nti  per-channel offset array (maps to ext_pfd_offset).
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when a run completes normally.
err  output  1  sticky timeout flag; cleared by start or rst.

Function
REQ-005 FSM states: IDLE, SELECT, SETTLE, MEASURE, UPDATE, DONE.
REQ-006 IDLE -> SELECT on start; chan_sel <= 0; iteration count <= 0; err <= 0.
REQ-007 SELECT -> SETTLE after 1 cycle; the settle counter loads settle_cycles.
REQ-008 SETTLE decrements its counter each cycle and exits to MEASURE when the counter reaches 0; settle_cycles = 0 gives 0 extra cycles.
REQ-009 meas_en is high only in MEASURE, and is registered (asserted on the cycle after entry).
REQ-010 MEASURE -> UPDATE on the cycle after avg_valid; avg_valid outside MEASURE is ignored.
REQ-011 UPDATE computes pfd_offset_out[chan_sel] <= sat(pfd_offset_out[chan_sel] + avg_in):
- the sum is formed Nadc+1 bits wide;
- it saturates to [-2^(Nadc-1), 2^(Nadc-1)-1].
REQ-012 After UPDATE, if chan_sel < Nti-1: chan_sel increments and the FSM goes to SELECT.
REQ-013 Otherwise chan_sel wraps to 0 and the iteration count increments; if iterations are still outstanding the FSM goes to SELECT, else to DONE.
REQ-014 DONE pulses done for exactly 1 cycle, then returns to IDLE.
REQ-015 start while busy is ignored.
REQ-016 abort has priority over every other transition, including a simultaneous avg_valid; the offset being updated is not written.
REQ-017 After abort, offsets keep their last written values; done does not pulse.
REQ-018 n_iter, settle_cycles and timeout_lim are sampled at start; later changes do not affect the run in progress.
REQ-019 Offsets persist across runs; each run refines them from their current values.

Reset
REQ-020 On rst high at a clock edge:
- FSM goes to IDLE; chan_sel = 0;
- meas_en = 0, busy = 0, done = 0, err = 0;
- all pfd_offset_out = 0; all counters = 0.
REQ-021 rst mid-run discards the run immediately; rst has priority over abort and start.

Configuration
REQ-022 The macro PFD_CAL_TIMEOUT_EN controls the timeout feature.
REQ-023 With PFD_CAL_TIMEOUT_EN defined:
- a 16-bit counter runs in MEASURE;
- if it reaches timeout_lim with no avg_valid, the FSM sets err, leaves that channel's offset unchanged and goes to UPDATE-skip, then proceeds as in REQ-012/013;
- done still pulses at the end of the run.
REQ-024 Without PFD_CAL_TIMEOUT_EN: MEASURE waits indefinitely, err is tied to 0, and timeout_lim is unused.

Verification
REQ-025 Bench scenarios:
- Nti=4, n_iter=1, settle=2; avg_in = {+3,-5,0,+7} -> offsets {3,-5,0,7}; done pulses once; busy low afterwards.
- Offset=120, avg_in=+20 (Nadc=8) -> offset 127; offset=-120, avg_in=-20 -> offset -128.
- n_iter=2, constant avg_in=+1 -> each offset = +2; chan_sel sequence 0..3,0..3.
- abort asserted in the same cycle as avg_valid on channel 2 -> channel 2 unchanged; IDLE next cycle; no done.
- With PFD_CAL_TIMEOUT_EN, timeout_lim=10, no avg_valid on channel 1 -> err=1 after 10 MEASURE cycles; channel 1 unchanged; run completes with done.
- rst in SETTLE -> next cycle IDLE, all outputs and offsets 0; start ignored while busy.
